// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: FSM state type and round-robin helper
// shared by the UART TX scheduler and its arbiter.
package uart_sched_pkg;

  localparam int MAX_REQ = 8;
  localparam int GRANT_W = $clog2(MAX_REQ);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_t;

  // First set bit searching upward from last+1 modulo n;
  // returns last when nothing is requesting.
  function automatic int rr_next(
    input logic [MAX_REQ-1:0] valid,
    input int                 last,
    input int                 n
  );
    int pick;
    int idx;
    pick = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (valid[idx[GRANT_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick,
// one-hot grant plus index.
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    gnt_idx_o = IW'(rr_next(MAX_REQ'(req_i),
                            int'(last_i), NUM_REQ));
    gnt_oh_o  = '0;
    if (|req_i) gnt_oh_o = NUM_REQ'(1) << gnt_idx_o;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: packet round-robin sharing of one UART TX.
// Build option: UART_SCHED_TIMEOUT_EN enables the LOAD stall abort.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_pulse
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_scheduler: bad parameters");
  end

  sched_state_t      state_q, state_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [IW-1:0]     lastg_q, lastg_d;
  logic [IW-1:0]     arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic              ga_q, ga_d;
  logic              last_q, last_d;
  logic              start_q, start_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              arb_any;
  logic              valid_g;
  logic              load_fire;
  logic              to_fire;
  logic              pkt_end;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .last_i    (lastg_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign arb_any   = |arb_oh;
  assign valid_g   = req_valid[gid_q];
  assign load_fire = (state_q == LOAD) && valid_g && !tx_busy;
  assign pkt_end   = (state_q == WAIT_DONE) && !tx_busy && last_q;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign to_fire = (state_q == LOAD) && !valid_g &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Busy stalls with data present hold the count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != LOAD || load_fire || to_fire) cnt_d = '0;
    else if (!valid_g) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable && arb_any) state_d = LOAD;
      LOAD: begin
        if (load_fire)    state_d = START;
        else if (to_fire) state_d = IDLE;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) state_d = last_q ? IDLE : LOAD;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    gid_d     = gid_q;
    ga_d      = ga_q;
    lastg_d   = lastg_q;
    last_d    = last_q;
    data_d    = data_q;
    start_d   = load_fire;
    to_d      = to_fire;
    req_ready = '0;
    if (state_q == IDLE && enable && arb_any) begin
      gid_d = arb_idx;
      ga_d  = 1'b1;
    end
    if (load_fire) begin
      req_ready = NUM_REQ'(1) << gid_q;
      data_d    = req_data[int'(gid_q)*DATA_W +: DATA_W];
      last_d    = req_last[gid_q];
    end
    if (pkt_end || to_fire) begin
      ga_d    = 1'b0;
      lastg_d = gid_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gid_q   <= '0;
      ga_q    <= 1'b0;
      lastg_q <= IW'(NUM_REQ - 1);
      last_q  <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      gid_q   <= gid_d;
      ga_q    <= ga_d;
      lastg_q <= lastg_d;
      last_q  <= last_d;
      data_q  <= data_d;
      start_q <= start_d;
      to_q    <= to_d;
    end
  end

  assign tx_start      = start_q;
  assign tx_data       = data_q;
  assign grant_active  = ga_q;
  assign grant_id      = gid_q;
  assign timeout_pulse = to_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed plan plus randomized packets
// against a queue-based round-robin reference model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            grant_active;
  logic [1:0]      grant_id;
  logic            timeout_pulse;

  uart_tx_scheduler #(
    .NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_active(grant_active),
    .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_len = 10;
  int   last_fall = 0;
  int   mlast = 3;
  bit   rand_mode = 0;
  int   gap [N];
  exp_t exp_q [$];
  // entry = {first, last, data}
  logic [9:0] pq [N][$];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic pk(input int r, input logic f,
                    input logic l, input logic [7:0] d);
    pq[r].push_back({f, l, d});
    exp_q.push_back({2'(r), d});
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && !grant_active) done = 1;
    end
    chk(done, {nm, "_done"}, exp_q.size(), 0);
  endtask

  // TX core: busy rises 1..2 cycles after tx_start.
  initial begin : txm
    int dly;
    int bcnt;
    dly = 0;
    bcnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (tx_busy) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_busy = 1'b0;
          last_fall = cyc;
        end
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1'b1;
          bcnt = (busy_len > 0) ? busy_len
                                : int'($urandom_range(1, 4));
        end
      end
      if (tx_start) dly = int'($urandom_range(1, 2));
    end
  end

  // Requester streams fed from pq.
  initial begin : drv
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(negedge ACLK);
      acc = req_ready;
      @(posedge ACLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
          if (pq[i].size() > 0 && !pq[i][0][9])
            gap[i] = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        req_valid[i] = pq[i].size() > 0 && gap[i] == 0;
        req_data[i*DW +: DW] =
          pq[i].size() > 0 ? pq[i][0][7:0] : 8'h00;
        req_last[i] = pq[i].size() > 0 && pq[i][0][8];
      end
    end
  end

  // Scoreboard monitor.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETN && tx_start) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_start", tx_data, 0);
        end else begin
          e = exp_q.pop_front();
          chk(tx_data == e.d, "tx_data", tx_data, e.d);
          chk(grant_id == e.id, "start_id", grant_id, e.id);
        end
      end
      if (ARESETN && req_ready != '0)
        chk(grant_active && !tx_busy &&
            req_ready == (4'(1) << grant_id) &&
            req_valid[grant_id],
            "ready_legal", req_ready, 4'(1) << grant_id);
    end
  end

  task automatic rand_round();
    logic [9:0] mq [N][$];
    logic [9:0] ent;
    int np;
    int len;
    int pick;
    int j;
    for (int i = 0; i < N; i++) begin
      np = int'($urandom_range(0, 3));
      for (int p = 0; p < np; p++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          ent = {b == 0, b == len - 1, 8'($urandom)};
          mq[i].push_back(ent);
          pq[i].push_back(ent);
        end
      end
    end
    // Whole packets granted round-robin over non-empty streams.
    for (int g = 0; g < 64; g++) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        j = (mlast + k) % N;
        if (pick < 0 && mq[j].size() > 0) pick = j;
      end
      if (pick < 0) break;
      do begin
        ent = mq[pick].pop_front();
        exp_q.push_back({2'(pick), ent[7:0]});
      end while (!ent[8]);
      mlast = pick;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got %0d want 0 cycles left", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    bit ok;
    bit seen;
    ARESETN = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge ACLK);
    chk(grant_active == 0, "rst_ga", grant_active, 0);
    chk(grant_id == 0, "rst_gid", grant_id, 0);
    chk(tx_start == 0, "rst_start", tx_start, 0);
    chk(tx_data == 0, "rst_data", tx_data, 0);
    chk(req_ready == 0, "rst_ready", req_ready, 0);
    chk(timeout_pulse == 0, "rst_to", timeout_pulse, 0);
    ARESETN = 1'b1;
    enable  = 1'b1;

    // contention straight after reset
    busy_len = 3;
    pk(0, 1, 1, 8'hA0);
    pk(2, 1, 1, 8'hC0);
    pk(3, 1, 1, 8'hD0);
    pk(0, 1, 1, 8'hA1);
    wait_done(300, "contend");

    // single requester, two bytes
    busy_len = 10;
    pk(1, 1, 0, 8'h41);
    pk(1, 0, 1, 8'h42);
    wait_done(200, "single");
    chk(grant_id == 1, "single_gid", grant_id, 1);
    chk(cyc - last_fall == 1, "single_drop",
        cyc - last_fall, 1);

    // packet lock
    busy_len = 4;
    pk(0, 1, 0, 8'hB0);
    pk(0, 0, 0, 8'hB1);
    pk(0, 0, 1, 8'hB2);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge ACLK);
      if (grant_active && grant_id == 0) seen = 1;
    end
    chk(seen, "lock_grant0", grant_id, 0);
    pk(1, 1, 1, 8'hE0);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge ACLK);
      if (!grant_active) seen = 1;
    end
    chk(seen && exp_q.size() == 1, "lock_end",
        exp_q.size(), 1);
    @(negedge ACLK);
    chk(grant_active && grant_id == 1, "lock_regrant",
        grant_id, 1);
    wait_done(200, "lock");

    // enable gating
    enable = 1'b0;
    pq[2].push_back({2'b10, 8'hF0});
    pq[2].push_back({2'b00, 8'hF1});
    pq[2].push_back({2'b01, 8'hF2});
    pq[3].push_back({2'b11, 8'hF3});
    pq[0].push_back({2'b11, 8'hF4});
    pq[1].push_back({2'b11, 8'hF5});
    ok = 1;
    repeat (50) begin
      @(negedge ACLK);
      if (grant_active || tx_start || req_ready != 0) ok = 0;
    end
    chk(ok, "en_hold", grant_active, 0);
    enable = 1'b1;
    exp_q.push_back({2'd2, 8'hF0});
    exp_q.push_back({2'd2, 8'hF1});
    exp_q.push_back({2'd2, 8'hF2});
    @(negedge ACLK);
    chk(grant_active && grant_id == 2, "en_grant",
        grant_id, 2);
    enable = 1'b0;
    wait_done(300, "en_pkt");
    ok = 1;
    repeat (10) begin
      @(negedge ACLK);
      if (grant_active) ok = 0;
    end
    chk(ok, "en_off_idle", grant_active, 0);
    enable = 1'b1;
    exp_q.push_back({2'd3, 8'hF3});
    exp_q.push_back({2'd0, 8'hF4});
    exp_q.push_back({2'd1, 8'hF5});
    wait_done(300, "en_rest");

    // stalled packet
    busy_len = 3;
`ifdef UART_SCHED_TIMEOUT_EN
    pk(2, 1, 0, 8'h55);
    pk(3, 1, 1, 8'h66);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge ACLK);
      if (timeout_pulse) seen = 1;
    end
    chk(seen, "to_seen", timeout_pulse, 1);
    chk(cyc - last_fall == TO + 1, "to_delay",
        cyc - last_fall, TO + 1);
    chk(!grant_active, "to_idle", grant_active, 0);
    @(negedge ACLK);
    chk(!timeout_pulse, "to_one_cycle", timeout_pulse, 0);
    wait_done(200, "to");
`else
    pk(2, 1, 0, 8'h55);
    repeat (30) @(negedge ACLK);
    ok = 1;
    repeat (100) begin
      @(negedge ACLK);
      if (!grant_active || grant_id != 2 || timeout_pulse)
        ok = 0;
    end
    chk(ok, "stall_hold", grant_id, 2);
    pk(2, 0, 1, 8'h56);
    pk(3, 1, 1, 8'h66);
    wait_done(200, "stall");
`endif

    // async reset in WAIT_DONE
    busy_len = 10;
    pk(1, 1, 1, 8'h71);
    wait_done(200, "pre_rst");
    pk(2, 1, 1, 8'h72);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge ACLK);
      if (tx_busy) seen = 1;
    end
    chk(seen, "rst_busy", tx_busy, 1);
    repeat (2) @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    chk(grant_active == 0, "arst_ga", grant_active, 0);
    chk(grant_id == 0, "arst_gid", grant_id, 0);
    chk(tx_start == 0, "arst_start", tx_start, 0);
    chk(tx_data == 0, "arst_data", tx_data, 0);
    chk(req_ready == 0, "arst_ready", req_ready, 0);
    chk(timeout_pulse == 0, "arst_to", timeout_pulse, 0);
    chk(exp_q.size() == 0, "arst_sb", exp_q.size(), 0);
    for (int i = 0; i < N; i++) pq[i].delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    pk(0, 1, 1, 8'h80);
    pk(3, 1, 1, 8'h83);
    wait_done(300, "post_rst");

    // randomized packets
    rand_mode = 1;
    busy_len  = 0;
    mlast     = 3;
    repeat (3) begin
      rand_round();
      wait_done(4000, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
